// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions.
// Contents:
//   KEY_W, NUM_ROUNDS, RK_ADDR_W  - key width, round count, round-key index width
//   ks_state_t                    - key-schedule FSM state (IDLE, EXPAND, DONE)
//   gf_mul, sbox                  - GF(2^8) helpers used by Key_Expansion
package aes_pkg;

    localparam int unsigned KEY_W      = 128;
    localparam int unsigned NUM_ROUNDS = 10;
    localparam int unsigned RK_ADDR_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } ks_state_t;

    // GF(2^8) multiply, reduction polynomial x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = '0;
        aa = a;
        bb = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // AES S-box: multiplicative inverse as x^254 (0 maps to 0), then the affine map.
    // x^254 = x^2 * x^4 * ... * x^128, so only squarings and six products are needed.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = gf_mul(x, x);
        inv = sq;
        for (int unsigned i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/key_schedule_seq_key_expansion.sv
// Key_Expansion: one combinational AES-128 key-schedule round.
// Ports:
//   round_number - round being produced, 1..10 (selects Rcon; other values give Rcon=0)
//   key          - previous round key, word 0 in [127:96]
//   next_key     - round key for round_number
module Key_Expansion
    import aes_pkg::*;
(
    input  logic [RK_ADDR_W-1:0] round_number,
    input  logic [KEY_W-1:0]     key,
    output logic [KEY_W-1:0]     next_key
);

    logic [7:0]  rcon;
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] temp;
    logic [31:0] n0, n1, n2, n3;

    always_comb begin
        case (round_number)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign {w0, w1, w2, w3} = key;

    // SubWord(RotWord(w3)) xor Rcon
    assign temp = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};

    assign n0 = w0 ^ temp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/key_schedule_seq.sv
// key_schedule_seq: sequential AES-128 round-key generator with an 11-entry bank.
// Ports:
//   clk, rst_n            - clock; synchronous active-low reset
//   key_in, key_valid     - cipher key handshake input
//   key_ready             - high in IDLE/DONE (new key can be accepted)
//   busy                  - high while expanding
//   keys_valid            - all 11 round keys stored
//   rk_addr, rk_rd        - round-key read address (0..10) and strobe
//   rk_data, rk_data_valid- registered read data (1-cycle latency) and its qualifier
module key_schedule_seq
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned KEY_W      = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [KEY_W-1:0]     key_in,
    input  logic                 key_valid,
    output logic                 key_ready,
    output logic                 busy,
    output logic                 keys_valid,
    input  logic [RK_ADDR_W-1:0] rk_addr,
    input  logic                 rk_rd,
    output logic [KEY_W-1:0]     rk_data,
    output logic                 rk_data_valid
);

    localparam logic [RK_ADDR_W-1:0] LAST_RND = RK_ADDR_W'(NUM_ROUNDS);

    ks_state_t             state, state_next;
    logic [RK_ADDR_W-1:0]  rnd;
    logic [KEY_W-1:0]      cur_key;
    logic [KEY_W-1:0]      next_key;
    logic [KEY_W-1:0]      bank [0:NUM_ROUNDS];
    logic                  accept;

    Key_Expansion u_key_expansion (
        .round_number (rnd),
        .key          (cur_key),
        .next_key     (next_key)
    );

    always_comb begin
        state_next = state;
        key_ready  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE, DONE: begin
                key_ready = 1'b1;
                if (key_valid) state_next = EXPAND;
            end
            EXPAND: begin
                busy = 1'b1;
                if (rnd == LAST_RND) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = key_valid & key_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            rnd           <= '0;
            cur_key       <= '0;
            keys_valid    <= 1'b0;
            rk_data       <= '0;
            rk_data_valid <= 1'b0;
            for (int unsigned i = 0; i <= NUM_ROUNDS; i++) bank[i] <= '0;
        end else begin
            state <= state_next;

            if (accept) begin
                bank[0]    <= key_in;
                cur_key    <= key_in;
                rnd        <= RK_ADDR_W'(1);
                keys_valid <= 1'b0;
            end else if (state == EXPAND) begin
                bank[rnd] <= next_key;
                cur_key   <= next_key;
                if (rnd == LAST_RND) begin
                    rnd        <= '0;
                    keys_valid <= 1'b1;
                end else begin
                    rnd <= rnd + RK_ADDR_W'(1);
                end
            end

            // Read samples the bank and keys_valid as they were before this edge,
            // so a read coinciding with a reload returns the old key's data.
            if (rk_rd) begin
                if (rk_addr <= LAST_RND) begin
                    rk_data       <= bank[rk_addr];
                    rk_data_valid <= keys_valid;
                end else begin
                    rk_data       <= '0;
                    rk_data_valid <= 1'b0;
                end
            end else begin
                rk_data_valid <= 1'b0;
            end
        end
    end

endmodule
